// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } tag_t;

    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_BYTE = 2'd2;

    localparam logic RD = 1'b1;
    localparam logic WR = 1'b0;

endpackage

// File: rtl/mem_arb_tagpipe.sv
// LATENCY-deep shift register carrying the read tag (valid + owner) from the
// grant cycle to the cycle the memory returns data.
module mem_arb_tagpipe
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic clk,
    input  logic reset,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stages [LATENCY];

    // NOTE: non-blocking assignments let every stage shift on the same edge;
    // blocking ones would ripple one tag through the whole pipe in one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: every stage is reset, not just the head -- a stale valid
            // bit left in any stage would emerge as a phantom rvalid.
            for (int i = 0; i < LATENCY; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= tag_in;
            for (int i = 1; i < LATENCY; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign tag_out = stages[LATENCY-1];

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto one pipelined memory port.
// Define MEM_ARB_RR_EN for round-robin contention; default is data-priority
// with an instruction starvation guard.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic        d_rd_wr,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_size,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,

    output logic        m_enable,
    output logic        m_rd_wr,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [1:0]  m_size,
    input  logic [31:0] m_rdata
);

    logic        i_win;
    tag_t        tag_in;
    tag_t        tag_out;
    logic [31:0] i_rdata_q;
    logic [31:0] d_rdata_q;

`ifdef MEM_ARB_RR_EN
    owner_e last_own;

    // On contention the port that won most recently yields.
    assign i_win = i_req && (!d_req || last_own == OWN_D);

    always_ff @(posedge clk) begin
        if (reset) begin
            last_own <= OWN_I;
        end else if (i_gnt) begin
            last_own <= OWN_I;
        end else if (d_gnt) begin
            last_own <= OWN_D;
        end
    end
`else
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [SW-1:0] starve_cnt;

    // Data wins contention until the fetch side has waited STARVE_MAX cycles.
    assign i_win = i_req && (!d_req || starve_cnt == STARVE_LIM);

    always_ff @(posedge clk) begin
        if (reset || !i_req || i_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`endif

    assign i_gnt = !reset && i_win;
    assign d_gnt = !reset && d_req && !i_win;

    // NOTE: every output gets a default before the branches, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        m_enable = i_gnt | d_gnt;
        m_rd_wr  = RD;
        m_addr   = '0;
        m_wdata  = '0;
        m_size   = SZ_WORD;
        if (i_gnt) begin
            m_addr = i_addr;
        end else if (d_gnt) begin
            m_rd_wr = d_rd_wr;
            m_addr  = d_addr;
            m_wdata = d_wdata;
            m_size  = d_size;
        end
    end

    assign tag_in.valid = i_gnt || (d_gnt && d_rd_wr == RD);
    assign tag_in.owner = d_gnt ? OWN_D : OWN_I;

    mem_arb_tagpipe #(
        .LATENCY (LATENCY)
    ) u_tagpipe (
        .clk     (clk),
        .reset   (reset),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign i_rvalid = !reset && tag_out.valid && tag_out.owner == OWN_I;
    assign d_rvalid = !reset && tag_out.valid && tag_out.owner == OWN_D;

    always_ff @(posedge clk) begin
        if (reset) begin
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if (i_rvalid) i_rdata_q <= m_rdata;
            if (d_rvalid) d_rdata_q <= m_rdata;
        end
    end

    // Returned data passes straight through in its cycle, then is held.
    assign i_rdata = reset ? '0 : (i_rvalid ? m_rdata : i_rdata_q);
    assign d_rdata = reset ? '0 : (d_rvalid ? m_rdata : d_rdata_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: three arbiters (LATENCY 1..3) share one stimulus stream and
// are checked against a cycle-level reference model of the arbitration rules.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int STARVE_MAX = 4;
    localparam int N_INST     = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_rd_wr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [1:0]  d_size;
    logic [31:0] m_rdata;

    logic [N_INST-1:0] i_gnt_w, i_rvalid_w, d_gnt_w, d_rvalid_w;
    logic [N_INST-1:0] m_enable_w, m_rd_wr_w;
    logic [31:0]       i_rdata_w [N_INST];
    logic [31:0]       d_rdata_w [N_INST];
    logic [31:0]       m_addr_w  [N_INST];
    logic [31:0]       m_wdata_w [N_INST];
    logic [1:0]        m_size_w  [N_INST];

    for (genvar g = 0; g < N_INST; g++) begin : g_dut
        mem_arbiter #(
            .LATENCY    (g + 1),
            .STARVE_MAX (STARVE_MAX)
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .i_req    (i_req),
            .i_addr   (i_addr),
            .i_gnt    (i_gnt_w[g]),
            .i_rvalid (i_rvalid_w[g]),
            .i_rdata  (i_rdata_w[g]),
            .d_req    (d_req),
            .d_rd_wr  (d_rd_wr),
            .d_addr   (d_addr),
            .d_wdata  (d_wdata),
            .d_size   (d_size),
            .d_gnt    (d_gnt_w[g]),
            .d_rvalid (d_rvalid_w[g]),
            .d_rdata  (d_rdata_w[g]),
            .m_enable (m_enable_w[g]),
            .m_rd_wr  (m_rd_wr_w[g]),
            .m_addr   (m_addr_w[g]),
            .m_wdata  (m_wdata_w[g]),
            .m_size   (m_size_w[g]),
            .m_rdata  (m_rdata)
        );
    end

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory returns a cycle-dependent word so misrouted or mistimed data shows up.
    function automatic logic [31:0] mem_word(input int c);
        return 32'hC0DE_0000 ^ (32'(c) * 32'h9E37_79B1);
    endfunction

    initial m_rdata = mem_word(0);
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1 m_rdata = mem_word(cyc);
    end

    // ---------------- reference model + monitor ----------------
    typedef struct {
        int     due;
        owner_e own;
    } exp_t;

    exp_t        sb [N_INST][$];
    int          starve   = 0;
    owner_e      last_own = OWN_I;
    logic [31:0] held_i [N_INST];
    logic [31:0] held_d [N_INST];

    initial begin
        for (int k = 0; k < N_INST; k++) begin
            held_i[k] = '0;
            held_d[k] = '0;
        end
    end

    always @(negedge clk) begin
        logic        exp_i, exp_d, exp_iv, exp_dv;
        logic [31:0] now_data, exp_ird, exp_drd;
        exp_t        e;
        string       tagn;
        now_data = mem_word(cyc);
        if (reset) begin
            exp_i = 1'b0;
            exp_d = 1'b0;
        end else begin
`ifdef MEM_ARB_RR_EN
            exp_i = i_req && (!d_req || last_own == OWN_D);
`else
            exp_i = i_req && (!d_req || starve >= STARVE_MAX);
`endif
            exp_d = d_req && !exp_i;
        end

        for (int k = 0; k < N_INST; k++) begin
            tagn = $sformatf("L%0d", k + 1);
            check({"gnt ", tagn}, {i_gnt_w[k], d_gnt_w[k]}, {exp_i, exp_d});
            if (reset) begin
                check({"rst_mport ", tagn},
                      {m_enable_w[k], m_rd_wr_w[k], m_size_w[k], m_addr_w[k], m_wdata_w[k]},
                      {1'b0, 1'b1, 2'd0, 32'd0, 32'd0});
                check({"rst_out ", tagn},
                      {i_rvalid_w[k], d_rvalid_w[k], i_rdata_w[k], d_rdata_w[k]},
                      {2'b00, 64'd0});
                sb[k].delete();
                held_i[k] = '0;
                held_d[k] = '0;
            end else begin
                if (exp_i)
                    check({"mport_i ", tagn},
                          {m_enable_w[k], m_rd_wr_w[k], m_size_w[k], m_addr_w[k], m_wdata_w[k]},
                          {1'b1, 1'b1, 2'd0, i_addr, 32'd0});
                else if (exp_d)
                    check({"mport_d ", tagn},
                          {m_enable_w[k], m_rd_wr_w[k], m_size_w[k], m_addr_w[k], m_wdata_w[k]},
                          {1'b1, d_rd_wr, d_size, d_addr, d_wdata});
                else
                    check({"m_enable ", tagn}, m_enable_w[k], 1'b0);

                exp_iv = 1'b0;
                exp_dv = 1'b0;
                if (sb[k].size() > 0 && sb[k][0].due == cyc) begin
                    e = sb[k].pop_front();
                    if (e.own == OWN_I) begin
                        exp_iv    = 1'b1;
                        held_i[k] = now_data;
                    end else begin
                        exp_dv    = 1'b1;
                        held_d[k] = now_data;
                    end
                end
                exp_ird = held_i[k];
                exp_drd = held_d[k];
                check({"rvalid ", tagn}, {i_rvalid_w[k], d_rvalid_w[k]}, {exp_iv, exp_dv});
                check({"rdata ", tagn}, {i_rdata_w[k], d_rdata_w[k]}, {exp_ird, exp_drd});

                if (exp_i) sb[k].push_back('{due: cyc + k + 1, own: OWN_I});
                else if (exp_d && d_rd_wr) sb[k].push_back('{due: cyc + k + 1, own: OWN_D});
            end
        end

        if (reset) begin
            starve   = 0;
            last_own = OWN_I;
        end else begin
            starve = (i_req && !exp_i) ? ((starve < STARVE_MAX) ? starve + 1 : STARVE_MAX) : 0;
            if (exp_i) last_own = OWN_I;
            else if (exp_d) last_own = OWN_D;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_rd_wr = RD;
        d_addr  = '0;
        d_wdata = '0;
        d_size  = SZ_WORD;
    endtask

    logic [5:0] seq_i;
    logic       gi, gd;

    initial begin
        reset = 1'b1;
        idle_inputs();
        repeat (3) step();
        reset = 1'b0;

        // Lone fetch read.
        i_req  = 1'b1;
        i_addr = 32'h8002_0000;
        step();
        idle_inputs();
        repeat (4) step();

        // Both ports requesting for six cycles from a clean state.
        reset = 1'b1;
        step();
        reset   = 1'b0;
        i_req   = 1'b1;
        i_addr  = 32'h8001_0000;
        d_req   = 1'b1;
        d_rd_wr = RD;
        d_addr  = 32'h8003_0000;
        for (int j = 0; j < 6; j++) begin
            #3 seq_i[j] = i_gnt_w[0];
            step();
        end
`ifdef MEM_ARB_RR_EN
        check("grant_seq", seq_i, 6'b101010);
`else
        check("grant_seq", seq_i, 6'b010000);
`endif
        idle_inputs();
        repeat (4) step();

        // Back-to-back I, D, I reads.
        i_req  = 1'b1;
        i_addr = 32'h0000_1000;
        step();
        i_req   = 1'b0;
        d_req   = 1'b1;
        d_rd_wr = RD;
        d_addr  = 32'h0000_2000;
        step();
        d_req  = 1'b0;
        i_req  = 1'b1;
        i_addr = 32'h0000_1004;
        step();
        idle_inputs();
        repeat (5) step();

        // Byte write: no read data ever returns for it.
        d_req   = 1'b1;
        d_rd_wr = WR;
        d_addr  = 32'h0000_3003;
        d_wdata = 32'hDEAD_BEEF;
        d_size  = SZ_BYTE;
        #3 check("write_mport", {m_enable_w[0], m_rd_wr_w[0], m_size_w[0]}, {1'b1, 1'b0, 2'd2});
        step();
        idle_inputs();
        repeat (5) step();

        // Reset one cycle after a fetch grant discards it.
        i_req  = 1'b1;
        i_addr = 32'h0000_4000;
        step();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (5) step();

        // Random traffic obeying hold-until-grant, with occasional withdrawal and reset.
        gi = 1'b0;
        gd = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            reset = ($urandom_range(199) == 0);
            if (i_req && !gi) begin
                if ($urandom_range(9) == 0) i_req = 1'b0;
            end else begin
                i_req  = ($urandom_range(9) < 6);
                i_addr = $urandom() & 32'hFFFF_FFFC;
            end
            if (d_req && !gd) begin
                if ($urandom_range(9) == 0) d_req = 1'b0;
            end else begin
                d_req   = ($urandom_range(9) < 6);
                d_rd_wr = $urandom_range(1) == 1;
                d_addr  = $urandom();
                d_wdata = $urandom();
                d_size  = 2'($urandom_range(2));
            end
            #3;
            gi = i_gnt_w[0];
            gd = d_gnt_w[0];
            step();
        end

        reset = 1'b0;
        idle_inputs();
        repeat (6) step();
        for (int k = 0; k < N_INST; k++) begin
            check($sformatf("drain L%0d", k + 1), sb[k].size(), 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
